// File: rtl/zle_ctl.sv
// Control FSM and output token FIFO for the zero run-length encoder datapath.
// The firing decision uses only registered FIFO occupancy, so o_ready never reaches fire combinationally.
module zle_ctl #(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ack,
  input  logic             f_start_i_eq_0,
  input  logic             f_zeros_i_eq_0,
  input  logic             f_zeros_cnt_eq_15,
  output logic [1:0]       state,
  output logic             fire,
  input  logic [3:0]       dp_o_d,
  output logic [3:0]       o_d,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [CNT_W-1:0] in_tok_cnt,
  output logic [CNT_W-1:0] out_tok_cnt
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_ZEROS = 2'd1,
    ST_PEND  = 2'd2,
    ST_ILL   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       mem_q [OUT_DEPTH];
  logic [3:0]       mem_d [OUT_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic full_s, fire_raw_s, emit_s, push_s, pop_s;
  logic fs_s, fz_s, fc_s;

  // Datapath flags are only meaningful with a valid input; masking keeps X off fire.
  assign fs_s = i_valid & f_start_i_eq_0;
  assign fz_s = i_valid & f_zeros_i_eq_0;
  assign fc_s = i_valid & f_zeros_cnt_eq_15;

  assign full_s  = (occ_q == OW'(OUT_DEPTH));
  assign o_valid = (occ_q != {OW{1'b0}});
  assign o_d     = mem_q[rd_ptr_q];
  assign state   = state_q;
  assign pop_s   = o_valid & o_ready;
  assign push_s  = fire & emit_s;
  assign fire    = fire_raw_s & reset;
  assign i_ack   = fire & ((state_q == ST_START) | (state_q == ST_ZEROS));

  assign in_tok_cnt  = in_cnt_q;
  assign out_tok_cnt = out_cnt_q;

  // Firing strobe and token-emit decision for the current state.
  always_comb begin
    fire_raw_s = 1'b0;
    emit_s     = 1'b0;
    case (state_q)
      ST_START: begin
        fire_raw_s = i_valid & (fs_s | !full_s);
        emit_s     = !fs_s;
      end
      ST_ZEROS: begin
        fire_raw_s = i_valid & !(fz_s & fc_s & full_s);
        emit_s     = fz_s & fc_s;
      end
      ST_PEND: begin
        fire_raw_s = !full_s;
        emit_s     = 1'b1;
      end
      default: begin
        fire_raw_s = 1'b0;
        emit_s     = 1'b0;
      end
    endcase
  end

  // Next-state selection; state advances only on a firing, illegal state recovers at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: begin
        if (fire) state_d = fs_s ? ST_ZEROS : ST_START;
        else      state_d = state_q;
      end
      ST_ZEROS: begin
        if (fire) state_d = fz_s ? ST_ZEROS : ST_PEND;
        else      state_d = state_q;
      end
      ST_PEND: begin
        if (fire) state_d = ST_START;
        else      state_d = state_q;
      end
      default: state_d = ST_START;
    endcase
  end

  // FIFO storage, pointers, occupancy and token counters.
  always_comb begin
    mem_d = mem_q;
    if (push_s) mem_d[wr_ptr_q] = dp_o_d;
    else        mem_d = mem_q;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    in_cnt_d  = in_cnt_q  + CNT_W'(i_ack);
    out_cnt_d = out_cnt_q + CNT_W'(pop_s);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_START;
    else        state_q <= state_d;
  end

  // FIFO and counter registers; reset discards any buffered tokens.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= 4'd0;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      occ_q     <= {OW{1'b0}};
      in_cnt_q  <= {CNT_W{1'b0}};
      out_cnt_q <= {CNT_W{1'b0}};
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_zle_ctl.sv
// Directed bench for zle_ctl; the bench plays the datapath by driving flags and dp_o_d itself.
// Per-cycle observation vector is {state, fire, i_ack, o_valid, o_d}, stimulus is {i_valid, fs, fz, fc, dp_o_d}.
module tb_zle_ctl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        fs = 1'b0, fz = 1'b0, fc = 1'b0;
  logic [3:0]  dp_o_d = 4'd0;
  logic        o_ready = 1'b0;
  logic        i_ack, fire, o_valid;
  logic [1:0]  state;
  logic [3:0]  o_d;
  logic [15:0] in_tok_cnt, out_tok_cnt;

  int n_pass = 0;
  int n_total = 0;

  zle_ctl #(.OUT_DEPTH(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_ack(i_ack),
    .f_start_i_eq_0(fs), .f_zeros_i_eq_0(fz), .f_zeros_cnt_eq_15(fc),
    .state(state), .fire(fire), .dp_o_d(dp_o_d), .o_d(o_d), .o_valid(o_valid),
    .o_ready(o_ready), .in_tok_cnt(in_tok_cnt), .out_tok_cnt(out_tok_cnt)
  );

  always #5 clock = ~clock;

  task automatic apply(input logic [7:0] s);
    {i_valid, fs, fz, fc, dp_o_d} = s;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply(8'h00);
    o_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    reset = 1'b0;
    apply(8'h83);
    o_ready = 1'b1;
    @(negedge clock);
    n_total++;
    if ({fire, i_ack} !== 2'b00) $display("FAIL reset_gate fire/ack got %b want 00", {fire, i_ack});
    else n_pass++;
    @(posedge clock);
    #1 reset = 1'b1;
    apply(8'h00);
    @(negedge clock);
    obs = {state, fire, i_ack, o_valid, o_d};
    n_total++;
    if (obs !== 9'b0) $display("FAIL reset_state got %b want %b", obs, 9'b0);
    else n_pass++;
    n_total++;
    if ({in_tok_cnt, out_tok_cnt} !== 32'd0) $display("FAIL reset_counters got %0d/%0d want 0/0", in_tok_cnt, out_tok_cnt);
    else n_pass++;
  endtask

  task automatic test_nonzero();
    logic [7:0] stim [4];
    logic [8:0] expv [4];
    logic [8:0] obs;
    do_reset();
    o_ready = 1'b1;
    stim = '{8'h83, 8'h85, 8'h87, 8'h00};
    expv = '{9'b00_1_1_0_0000, 9'b00_1_1_1_0011, 9'b00_1_1_1_0101, 9'b00_0_0_1_0111};
    for (int k = 0; k < 4; k++) begin
      apply(stim[k]);
      @(negedge clock);
      obs = {state, fire, i_ack, o_valid, o_d};
      n_total++;
      if (obs !== expv[k]) $display("FAIL nonzero k=%0d got %b want %b", k, obs, expv[k]);
      else n_pass++;
      tick();
    end
    @(negedge clock);
    n_total++;
    if ({o_valid, in_tok_cnt, out_tok_cnt} !== {1'b0, 16'd3, 16'd3})
      $display("FAIL nonzero_cnt got ov=%b in=%0d out=%0d want ov=0 in=3 out=3", o_valid, in_tok_cnt, out_tok_cnt);
    else n_pass++;
  endtask

  task automatic test_zero_zero_four();
    logic [7:0] stim [5];
    logic [8:0] expv [5];
    logic [8:0] obs;
    do_reset();
    o_ready = 1'b1;
    stim = '{8'hC0, 8'hA0, 8'h84, 8'h04, 8'h00};
    expv = '{9'b00_1_1_0_0000, 9'b01_1_1_0_0000, 9'b01_1_1_0_0000,
             9'b10_1_0_0_0000, 9'b00_0_0_1_0100};
    for (int k = 0; k < 5; k++) begin
      apply(stim[k]);
      @(negedge clock);
      obs = {state, fire, i_ack, o_valid, o_d};
      n_total++;
      if (obs !== expv[k]) $display("FAIL zero_zero_four k=%0d got %b want %b", k, obs, expv[k]);
      else n_pass++;
      if (k < 4) tick();
    end
    n_total++;
    if (in_tok_cnt !== 16'd3) $display("FAIL zero_zero_four_cnt got %0d want 3", in_tok_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_sixteen_zeros();
    logic [8:0] obs;
    logic [8:0] want;
    do_reset();
    o_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 0) begin
        apply(8'hC0);
        want = 9'b00_1_1_0_0000;
      end else if (k < 15) begin
        apply(8'hA0);
        want = 9'b01_1_1_0_0000;
      end else if (k == 15) begin
        apply(8'hBF);
        want = 9'b01_1_1_0_0000;
      end else begin
        apply(8'h00);
        want = 9'b01_0_0_1_1111;
      end
      @(negedge clock);
      obs = {state, fire, i_ack, o_valid, o_d};
      n_total++;
      if (obs !== want) $display("FAIL sixteen_zeros k=%0d got %b want %b", k, obs, want);
      else n_pass++;
      if (k < 16) tick();
    end
    n_total++;
    if (in_tok_cnt !== 16'd16) $display("FAIL sixteen_zeros_cnt got %0d want 16", in_tok_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] stim [7];
    logic [8:0] expv [7];
    logic [8:0] obs;
    do_reset();
    stim = '{8'h81, 8'h82, 8'h83, 8'h83, 8'h83, 8'h83, 8'h00};
    expv = '{9'b00_1_1_0_0000, 9'b00_1_1_1_0001, 9'b00_0_0_1_0001, 9'b00_0_0_1_0001,
             9'b00_0_0_1_0001, 9'b00_1_1_1_0010, 9'b00_0_0_1_0011};
    for (int k = 0; k < 7; k++) begin
      apply(stim[k]);
      o_ready = (k >= 4);
      @(negedge clock);
      obs = {state, fire, i_ack, o_valid, o_d};
      n_total++;
      if (obs !== expv[k]) $display("FAIL backpressure k=%0d got %b want %b", k, obs, expv[k]);
      else n_pass++;
      tick();
    end
    @(negedge clock);
    n_total++;
    if ({o_valid, in_tok_cnt, out_tok_cnt} !== {1'b0, 16'd3, 16'd3})
      $display("FAIL backpressure_cnt got ov=%b in=%0d out=%0d want ov=0 in=3 out=3", o_valid, in_tok_cnt, out_tok_cnt);
    else n_pass++;
  endtask

  // Leaves the DUT in the zeros state with a full FIFO, mid-cycle, for test_mid_reset.
  task automatic test_full_zeros();
    logic [7:0] stim [5];
    logic [8:0] expv [5];
    logic [8:0] obs;
    do_reset();
    o_ready = 1'b0;
    stim = '{8'h81, 8'h82, 8'hC0, 8'hA0, 8'hA0};
    expv = '{9'b00_1_1_0_0000, 9'b00_1_1_1_0001, 9'b00_1_1_1_0001,
             9'b01_1_1_1_0001, 9'b01_1_1_1_0001};
    for (int k = 0; k < 5; k++) begin
      apply(stim[k]);
      @(negedge clock);
      obs = {state, fire, i_ack, o_valid, o_d};
      n_total++;
      if (obs !== expv[k]) $display("FAIL full_zeros k=%0d got %b want %b", k, obs, expv[k]);
      else n_pass++;
      if (k < 4) tick();
    end
    n_total++;
    if (in_tok_cnt !== 16'd4) $display("FAIL full_zeros_cnt got %0d want 4", in_tok_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [8:0] obs;
    #2 reset = 1'b0;
    #1;
    obs = {state, fire, i_ack, o_valid, o_d};
    n_total++;
    if ({obs, in_tok_cnt, out_tok_cnt} !== {9'b0, 16'd0, 16'd0})
      $display("FAIL mid_reset got %b in=%0d out=%0d want %b in=0 out=0", obs, in_tok_cnt, out_tok_cnt, 9'b0);
    else n_pass++;
    #1 reset = 1'b1;
    apply(8'h00);
  endtask

  initial begin
    test_reset();
    test_nonzero();
    test_zero_zero_four();
    test_sixteen_zeros();
    test_backpressure();
    test_full_zeros();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
